// File: rtl/pelican_key_schedule_pkg.sv
// pelican_key_schedule_pkg: shared constants, state encoding and helpers for the key schedule
package pelican_key_schedule_pkg;
   localparam int         ROUNDS_DEF  = 40;
   localparam logic [5:0] RC_INIT_DEF = 6'h01;
   localparam int         KW          = 16;
   localparam int         K0          = 0;
   localparam int         K1          = 1;
   localparam int         K4          = 4;
   localparam int         K5          = 5;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
      return (x >> n) | (x << (16 - n));
   endfunction
endpackage

// File: rtl/pelican_rc_lfsr.sv
// pelican_rc_lfsr: 6-bit round-constant LFSR with restart and advance
module pelican_rc_lfsr
   import pelican_key_schedule_pkg::*;
#(
   parameter logic [5:0] P_INIT = RC_INIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic       i_adv,
   output logic [5:0] o_rc
);
   logic [5:0] r_rc;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_rc <= P_INIT;
      else if (i_load) r_rc <= P_INIT;
      else if (i_adv) r_rc <= {r_rc[4:0], ~(r_rc[5] ^ r_rc[4])};
   assign o_rc = r_rc;
endmodule

// File: rtl/pelican_key_schedule.sv
// pelican_key_schedule: per-round key words and round constant for the GIFT-128-style round function
module pelican_key_schedule
   import pelican_key_schedule_pkg::*;
#(
   parameter int         ROUNDS  = ROUNDS_DEF,
   parameter logic [5:0] RC_INIT = RC_INIT_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [127:0] i_key_in,
   input  logic         i_step,
   output logic [31:0]  o_key0,
   output logic [31:0]  o_key2,
   output logic [5:0]   o_rc,
   output logic [5:0]   o_round_idx,
   output logic         o_busy,
   output logic         o_last,
   output logic         o_done
);
   localparam logic [5:0] LAST = 6'(ROUNDS - 1);
   state_t       r_state, w_next;
   logic [127:0] r_key;
   logic [5:0]   r_idx;
   logic         w_run_step, w_at_last, w_adv;
   assign w_run_step = (r_state == S_RUN) && i_step && !i_load;
   assign w_at_last  = (r_idx == LAST);
   assign w_adv      = w_run_step && !w_at_last;
   always_comb begin
      w_next = r_state;
      w_next = i_load                   ? S_RUN  :
               (w_run_step && w_at_last) ? S_DONE :
               (r_state == S_DONE)       ? S_IDLE : r_state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else r_state <= w_next;
   // the two top words are rotated copies of k1/k0; the rest shifts down two words
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_key <= '0;
         r_idx <= '0;
      end else if (i_load) begin
         r_key <= i_key_in;
         r_idx <= '0;
      end else if (w_adv) begin
         r_key <= {rotr16(r_key[K1*KW +: KW], 2), rotr16(r_key[K0*KW +: KW], 12), r_key[127:32]};
         r_idx <= r_idx + 6'd1;
      end
   pelican_rc_lfsr #(.P_INIT(RC_INIT)) u_rc (
      .clk   (clk),
      .rst_n (rst_n),
      .i_load(i_load),
      .i_adv (w_adv),
      .o_rc  (o_rc)
   );
   assign o_key0      = {r_key[K1*KW +: KW], r_key[K0*KW +: KW]};
   assign o_key2      = {r_key[K5*KW +: KW], r_key[K4*KW +: KW]};
   assign o_round_idx = r_idx;
   assign o_busy      = (r_state == S_RUN);
   assign o_last      = o_busy && w_at_last;
   assign o_done      = (r_state == S_DONE);
endmodule

// File: tb/tb_pelican_key_schedule.sv
// tb_pelican_key_schedule: random and directed checks against a word-level reference model
module tb_pelican_key_schedule;
   localparam int R = 40;
   logic         clk = 1'b0, rst_n = 1'b0;
   logic         i_load = 1'b0, i_step = 1'b0;
   logic [127:0] i_key_in = '0;
   logic [31:0]  o_key0, o_key2;
   logic [5:0]   o_rc, o_round_idx;
   logic         o_busy, o_last, o_done;
   int n_chk = 0, n_fail = 0;
   logic [15:0] m_w [8];
   int          m_rc, m_idx, m_st;
   logic [127:0] k_a, k_b;
   logic [5:0]  rc_tab [10];
   int          n_done;

   pelican_key_schedule #(.ROUNDS(R), .RC_INIT(6'h01)) dut (
      .clk(clk), .rst_n(rst_n), .i_load(i_load), .i_key_in(i_key_in), .i_step(i_step),
      .o_key0(o_key0), .o_key2(o_key2), .o_rc(o_rc), .o_round_idx(o_round_idx),
      .o_busy(o_busy), .o_last(o_last), .o_done(o_done)
   );
   always #5 clk = ~clk;

   function automatic logic [15:0] rr(input logic [15:0] x, input int n);
      logic [31:0] d;
      d = {x, x} >> n;
      return d[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 8; i++) m_w[i] = '0;
      m_rc = 1; m_idx = 0; m_st = 0;
   endtask

   task automatic m_cycle(input logic l, input logic [127:0] k, input logic s);
      logic [15:0] o [8];
      if (l) begin
         for (int i = 0; i < 8; i++) m_w[i] = k[16*i +: 16];
         m_rc = 1; m_idx = 0; m_st = 1;
      end else if (m_st == 1 && s) begin
         if (m_idx < R - 1) begin
            o = m_w;
            for (int i = 0; i < 6; i++) m_w[i] = o[i+2];
            m_w[6] = rr(o[0], 12);
            m_w[7] = rr(o[1], 2);
            m_rc = ((m_rc << 1) & 63) | (((m_rc >> 5) ^ (m_rc >> 4) ^ 1) & 1);
            m_idx++;
         end else m_st = 2;
      end else if (m_st == 2) m_st = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".key0"}, o_key0, {m_w[1], m_w[0]});
      chk({tag, ".key2"}, o_key2, {m_w[5], m_w[4]});
      chk({tag, ".rc"}, 32'(o_rc), 32'(m_rc));
      chk({tag, ".idx"}, 32'(o_round_idx), 32'(m_idx));
      chk({tag, ".busy"}, 32'(o_busy), 32'(m_st == 1));
      chk({tag, ".last"}, 32'(o_last), 32'(m_st == 1 && m_idx == R - 1));
      chk({tag, ".done"}, 32'(o_done), 32'(m_st == 2));
   endtask

   task automatic cyc(input logic l, input logic [127:0] k, input logic s, input string tag);
      @(negedge clk);
      i_load = l; i_key_in = k; i_step = s;
      @(posedge clk);
      m_cycle(l, k, s);
      #1;
      check_all(tag);
   endtask

   initial begin
      rc_tab = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F};
      m_reset();
      #12;
      check_all("reset");
      @(negedge clk) rst_n = 1'b1;
      cyc(0, '0, 1, "idle_step");
      k_a = {16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1, 16'h0};
      cyc(1, k_a, 0, "load");
      chk("load.key0_const", o_key0, 32'h00010000);
      chk("load.key2_const", o_key2, 32'h00050004);
      cyc(0, '0, 1, "step1");
      chk("step1.key0_const", o_key0, 32'h00030002);
      chk("step1.key2_const", o_key2, 32'h00070006);
      chk("step1.k7k6", dut.r_key[127:96], 32'h40000000);
      // full block with random key, step held high through DONE
      k_b = {$urandom, $urandom, $urandom, $urandom};
      cyc(1, k_b, 0, "load_b");
      n_done = 0;
      for (int r = 0; r < R + 3; r++) begin
         if (r < 10) chk("rc_seq", 32'(o_rc), 32'(rc_tab[r]));
         cyc(0, '0, 1, $sformatf("run%0d", r));
         if (o_done) n_done++;
      end
      chk("done_count", 32'(n_done), 32'd1);
      cyc(0, '0, 1, "idle_after_done");
      // load collides with step mid-block
      cyc(1, {$urandom, $urandom, $urandom, $urandom}, 0, "load_c");
      for (int r = 0; r < 17; r++) cyc(0, '0, ($urandom_range(0, 3) != 0) || (r > 12), "run_c");
      while (m_idx < 17) cyc(0, '0, 1, "run_c2");
      cyc(1, {$urandom, $urandom, $urandom, $urandom}, 1, "load_step");
      for (int r = 0; r < 5; r++) cyc(0, '0, 1, "run_d");
      // asynchronous reset in the middle of a cycle
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      check_all("areset");
      @(negedge clk) rst_n = 1'b1;
      for (int r = 0; r < 3; r++) cyc(0, '0, 1, "post_reset_step");
      // a short block ending with load during DONE
      cyc(1, {$urandom, $urandom, $urandom, $urandom}, 0, "load_e");
      while (m_st == 1) cyc(0, '0, 1, "run_e");
      cyc(1, k_a, 0, "load_in_done");
      cyc(0, '0, 0, "hold");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
